// File: rtl/rv32i_pkg.sv
// Shared types for the RV32I fetch/load-store memory arbiter.
// Holds FSM states, requester ids and datapath widths.
package rv32i_pkg;

  localparam int XLEN = 32;
  localparam int BE_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT
  } state_e;

  typedef enum logic {
    OWN_IF,
    OWN_LS
  } owner_e;

endpackage

// File: rtl/rv32i_arb_pick.sv
// Combinational winner select between fetch and load/store.
// RV32I_ARB_RR_EN adds a last-grant input for round-robin.
module rv32i_arb_pick
  import rv32i_pkg::*;
(
  input  logic   if_req,
  input  logic   ls_req,
`ifdef RV32I_ARB_RR_EN
  input  owner_e last,
`endif
  output logic   valid,
  output owner_e win
);

  // pick the winner among active requests
  always_comb begin
    valid = if_req | ls_req;
    win   = OWN_IF;
`ifdef RV32I_ARB_RR_EN
    if (ls_req && if_req)
      win = (last == OWN_LS) ? OWN_IF : OWN_LS;
    else if (ls_req)
      win = OWN_LS;
`else
    if (ls_req)
      win = OWN_LS;
`endif
  end

endmodule

// File: rtl/rv32i_mem_arb.sv
// Single-outstanding memory arbiter for fetch and load/store.
// Define RV32I_ARB_RR_EN for round-robin instead of Ls-first.
module rv32i_mem_arb
  import rv32i_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              If_Req,
  input  logic [ADDR_W-1:0] If_Addr,
  output logic              If_Gnt,
  output logic              If_Rvalid,
  input  logic              Ls_Req,
  input  logic              Ls_We,
  input  logic [BE_W-1:0]   Ls_Be,
  input  logic [ADDR_W-1:0] Ls_Addr,
  input  logic [XLEN-1:0]   Ls_Wdata,
  output logic              Ls_Gnt,
  output logic              Ls_Rvalid,
  output logic [XLEN-1:0]   Rdata,
  output logic              Mem_Req,
  output logic              Mem_We,
  output logic [BE_W-1:0]   Mem_Be,
  output logic [ADDR_W-1:0] Mem_Addr,
  output logic [XLEN-1:0]   Mem_Wdata,
  input  logic              Mem_Ready,
  input  logic              Mem_Rvalid,
  input  logic [XLEN-1:0]   Mem_Rdata,
  output logic              Err
);

  state_e state, state_nx;
  owner_e owner, win;
  logic   win_vld, take, win_ls;
  logic   if_gnt_q, ls_gnt_q, err_q;

  // owner doubles as the last-grant pointer
  rv32i_arb_pick u_pick (
    .if_req (If_Req),
    .ls_req (Ls_Req),
`ifdef RV32I_ARB_RR_EN
    .last   (owner),
`endif
    .valid  (win_vld),
    .win    (win)
  );

  assign win_ls = (win == OWN_LS);

  // next-state and accept decision
  always_comb begin
    state_nx = state;
    take     = 1'b0;
    unique case (state)
      IDLE: begin
        if (win_vld) begin
          state_nx = ISSUE;
          take     = 1'b1;
        end
      end
      ISSUE:   if (Mem_Ready) state_nx = WAIT;
      WAIT:    if (Mem_Rvalid) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // state register
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) state <= IDLE;
    else      state <= state_nx;
  end

  // latch the granted request, grant pulses and error flag
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      owner     <= OWN_IF;
      if_gnt_q  <= 1'b0;
      ls_gnt_q  <= 1'b0;
      err_q     <= 1'b0;
      Mem_We    <= 1'b0;
      Mem_Be    <= '0;
      Mem_Addr  <= '0;
      Mem_Wdata <= '0;
    end else begin
      if_gnt_q <= take && !win_ls;
      ls_gnt_q <= take && win_ls;
      if (Mem_Rvalid && state != WAIT)
        err_q <= 1'b1;
      if (take) begin
        owner     <= win;
        Mem_We    <= win_ls && Ls_We;
        Mem_Be    <= win_ls ? Ls_Be : '1;
        Mem_Addr  <= win_ls ? Ls_Addr : If_Addr;
        Mem_Wdata <= win_ls ? Ls_Wdata : '0;
      end
    end
  end

  assign Mem_Req   = (state == ISSUE);
  assign If_Gnt    = if_gnt_q;
  assign Ls_Gnt    = ls_gnt_q;
  assign Err       = err_q;
  assign If_Rvalid = (state == WAIT) && Mem_Rvalid
                     && (owner == OWN_IF);
  assign Ls_Rvalid = (state == WAIT) && Mem_Rvalid
                     && (owner == OWN_LS);
  assign Rdata     = (state == WAIT) ? Mem_Rdata : '0;

endmodule

// File: tb/tb_rv32i_mem_arb.sv
// Self-checking bench for rv32i_mem_arb.
// Directed scenarios plus a randomized transaction model.
module tb_rv32i_mem_arb;

  logic        Clk = 1'b0;
  logic        Rst = 1'b0;
  logic        If_Req = 1'b0;
  logic [31:0] If_Addr = '0;
  logic        If_Gnt, If_Rvalid;
  logic        Ls_Req = 1'b0;
  logic        Ls_We = 1'b0;
  logic [3:0]  Ls_Be = '0;
  logic [31:0] Ls_Addr = '0;
  logic [31:0] Ls_Wdata = '0;
  logic        Ls_Gnt, Ls_Rvalid;
  logic [31:0] Rdata;
  logic        Mem_Req, Mem_We;
  logic [3:0]  Mem_Be;
  logic [31:0] Mem_Addr, Mem_Wdata;
  logic        Mem_Ready = 1'b0;
  logic        Mem_Rvalid = 1'b0;
  logic [31:0] Mem_Rdata = '0;
  logic        Err;

  int n_cmp = 0;
  int n_bad = 0;
  bit last_ls = 1'b0;

`ifdef RV32I_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  rv32i_mem_arb #(.ADDR_W(32)) dut (
    .Clk(Clk), .Rst(Rst),
    .If_Req(If_Req), .If_Addr(If_Addr),
    .If_Gnt(If_Gnt), .If_Rvalid(If_Rvalid),
    .Ls_Req(Ls_Req), .Ls_We(Ls_We), .Ls_Be(Ls_Be),
    .Ls_Addr(Ls_Addr), .Ls_Wdata(Ls_Wdata),
    .Ls_Gnt(Ls_Gnt), .Ls_Rvalid(Ls_Rvalid),
    .Rdata(Rdata),
    .Mem_Req(Mem_Req), .Mem_We(Mem_We), .Mem_Be(Mem_Be),
    .Mem_Addr(Mem_Addr), .Mem_Wdata(Mem_Wdata),
    .Mem_Ready(Mem_Ready), .Mem_Rvalid(Mem_Rvalid),
    .Mem_Rdata(Mem_Rdata), .Err(Err)
  );

  always #5 Clk = ~Clk;

  task automatic cyc();
    @(posedge Clk);
    #1;
  endtask

  // {If_Gnt, Ls_Gnt, If_Rvalid, Ls_Rvalid, Mem_Req, Err}
  function automatic logic [5:0] fl();
    return {If_Gnt, Ls_Gnt, If_Rvalid, Ls_Rvalid, Mem_Req, Err};
  endfunction

  task automatic test_reset();
    Rst = 1'b0;
    If_Req = 0; Ls_Req = 0; Mem_Ready = 0; Mem_Rvalid = 0;
    cyc(); cyc();
    n_cmp++;
    if (fl() !== 6'b0) begin
      n_bad++;
      $display("FAIL reset_flags: got %b want %b", fl(), 6'b0);
    end
    n_cmp++;
    if ({Mem_We, Mem_Be, Mem_Addr, Mem_Wdata, Rdata} !== '0) begin
      n_bad++;
      $display("FAIL reset_fields: got %h want 0",
               {Mem_We, Mem_Be, Mem_Addr, Mem_Wdata, Rdata});
    end
    Rst = 1'b1;
    last_ls = 1'b0;
  endtask

  task automatic test_single_fetch();
    cyc();
    If_Req = 1; If_Addr = 32'h100; Mem_Ready = 1;
    #1;
    n_cmp++;
    if (fl() !== 6'b000000) begin
      n_bad++;
      $display("FAIL fetch_c0: got %b want %b", fl(), 6'b0);
    end
    cyc();
    n_cmp++;
    if (fl() !== 6'b100010 || Mem_Addr !== 32'h100 || Mem_We !== 1'b0) begin
      n_bad++;
      $display("FAIL fetch_c1: got %b/%h want 100010/100", fl(), Mem_Addr);
    end
    If_Req = 0;
    cyc();
    Mem_Ready = 0; Mem_Rvalid = 1; Mem_Rdata = 32'h00500293;
    #1;
    n_cmp++;
    if (fl() !== 6'b001000 || Rdata !== 32'h00500293) begin
      n_bad++;
      $display("FAIL fetch_c2: got %b/%h want 001000/00500293", fl(), Rdata);
    end
    cyc();
    Mem_Rvalid = 0;
    #1;
    n_cmp++;
    if (fl() !== 6'b0) begin
      n_bad++;
      $display("FAIL fetch_c3: got %b want %b", fl(), 6'b0);
    end
    last_ls = 1'b0;
  endtask

  task automatic test_stall();
    cyc();
    Ls_Req = 1; Ls_We = 0; Ls_Be = 4'hF; Ls_Addr = 32'h300;
    Mem_Ready = 0;
    cyc();
    n_cmp++;
    if (fl() !== 6'b010010 || Mem_Addr !== 32'h300) begin
      n_bad++;
      $display("FAIL stall_c1: got %b/%h want 010010/300", fl(), Mem_Addr);
    end
    Ls_Req = 0;
    for (int s = 2; s <= 4; s++) begin
      cyc();
      Mem_Ready = (s == 4);
      #1;
      n_cmp++;
      if (fl() !== 6'b000010 || Mem_Addr !== 32'h300) begin
        n_bad++;
        $display("FAIL stall_c%0d: got %b/%h want 000010/300",
                 s, fl(), Mem_Addr);
      end
    end
    cyc();
    Mem_Ready = 0;
    #1;
    n_cmp++;
    if (fl() !== 6'b0) begin
      n_bad++;
      $display("FAIL stall_wait: got %b want 000000", fl());
    end
    cyc();
    Mem_Rvalid = 1; Mem_Rdata = 32'hA5A50F0F;
    #1;
    n_cmp++;
    if (fl() !== 6'b000100 || Rdata !== 32'hA5A50F0F) begin
      n_bad++;
      $display("FAIL stall_resp: got %b/%h want 000100/a5a50f0f", fl(), Rdata);
    end
    cyc();
    Mem_Rvalid = 0;
    last_ls = 1'b1;
  endtask

  task automatic test_store();
    cyc();
    Ls_Req = 1; Ls_We = 1; Ls_Be = 4'h3;
    Ls_Addr = 32'h40; Ls_Wdata = 32'hDEADBEEF; Mem_Ready = 1;
    cyc();
    n_cmp++;
    if ({Mem_We, Mem_Be, Mem_Addr, Mem_Wdata}
        !== {1'b1, 4'h3, 32'h40, 32'hDEADBEEF} || fl() !== 6'b010010) begin
      n_bad++;
      $display("FAIL store_fields: got %b %h %h %h want 1 3 40 deadbeef",
               Mem_We, Mem_Be, Mem_Addr, Mem_Wdata);
    end
    Ls_Req = 0;
    cyc();
    Mem_Ready = 0; Mem_Rvalid = 1;
    #1;
    n_cmp++;
    if (fl() !== 6'b000100) begin
      n_bad++;
      $display("FAIL store_ack: got %b want 000100", fl());
    end
    cyc();
    Mem_Rvalid = 0; Ls_We = 0;
    last_ls = 1'b1;
  endtask

  task automatic test_conflict();
    bit          w_ls [3];
    logic [31:0] w_ad [3];
    test_reset();
    w_ls[0] = 1; w_ad[0] = 32'h2000;
    if (RR) begin
      w_ls[1] = 0; w_ad[1] = 32'h100;
      w_ls[2] = 1; w_ad[2] = 32'h2004;
    end else begin
      w_ls[1] = 1; w_ad[1] = 32'h2004;
      w_ls[2] = 0; w_ad[2] = 32'h100;
    end
    for (int k = 0; k < 3; k++) begin
      cyc();
      Mem_Rvalid = 0; Mem_Ready = 1;
      if (k == 0) begin
        If_Req = 1; If_Addr = 32'h100;
        Ls_Req = 1; Ls_We = 0; Ls_Be = 4'hF; Ls_Addr = 32'h2000;
      end
      #1;
      n_cmp++;
      if (fl() !== 6'b0) begin
        n_bad++;
        $display("FAIL conf%0d_idle: got %b want 000000", k, fl());
      end
      cyc();
      n_cmp++;
      if (fl() !== (w_ls[k] ? 6'b010010 : 6'b100010)
          || Mem_Addr !== w_ad[k]) begin
        n_bad++;
        $display("FAIL conf%0d_gnt: got %b/%h want ls=%0d/%h",
                 k, fl(), Mem_Addr, w_ls[k], w_ad[k]);
      end
      if (k == 0) Ls_Addr = 32'h2004;
      else if (w_ls[k]) Ls_Req = 0;
      else If_Req = 0;
      cyc();
      Mem_Ready = 0; Mem_Rvalid = 1; Mem_Rdata = 32'(k + 7);
      #1;
      n_cmp++;
      if (fl() !== (w_ls[k] ? 6'b000100 : 6'b001000)
          || Rdata !== 32'(k + 7)) begin
        n_bad++;
        $display("FAIL conf%0d_resp: got %b/%h want ls=%0d/%h",
                 k, fl(), Rdata, w_ls[k], k + 7);
      end
    end
    cyc();
    Mem_Rvalid = 0;
    last_ls = w_ls[2];
  endtask

  task automatic test_protocol();
    cyc();
    Mem_Rvalid = 1; Mem_Rdata = 32'h1234;
    #1;
    n_cmp++;
    if (fl() !== 6'b0) begin
      n_bad++;
      $display("FAIL proto_idle: got %b want 000000", fl());
    end
    cyc();
    Mem_Rvalid = 0;
    #1;
    n_cmp++;
    if (fl() !== 6'b000001) begin
      n_bad++;
      $display("FAIL proto_err: got %b want 000001", fl());
    end
  endtask

  task automatic test_reset_mid();
    test_reset();
    cyc();
    If_Req = 1; If_Addr = 32'h500; Mem_Ready = 1;
    cyc();
    If_Req = 0;
    cyc();
    Mem_Ready = 0;
    Rst = 0;
    #1;
    n_cmp++;
    if (fl() !== 6'b0
        || {Mem_We, Mem_Be, Mem_Addr, Mem_Wdata, Rdata} !== '0) begin
      n_bad++;
      $display("FAIL rst_mid: got %b/%h want 000000/0", fl(), Mem_Addr);
    end
    cyc();
    Rst = 1;
    cyc();
    Mem_Rvalid = 1;
    #1;
    n_cmp++;
    if (fl() !== 6'b0) begin
      n_bad++;
      $display("FAIL rst_late: got %b want 000000", fl());
    end
    cyc();
    Mem_Rvalid = 0;
    #1;
    n_cmp++;
    if (fl() !== 6'b000001) begin
      n_bad++;
      $display("FAIL rst_late_err: got %b want 000001", fl());
    end
  endtask

  task automatic test_random();
    bit          p_if, p_ls, w_ls, l_we;
    logic [31:0] i_ad, l_ad, l_wd, e_ad, rd;
    logic [3:0]  l_be;
    int          stall, dly;
    test_reset();
    p_if = 0; p_ls = 0;
    i_ad = 0; l_ad = 0; l_wd = 0; l_be = 0; l_we = 0;
    for (int it = 0; it < 60; it++) begin
      cyc();
      Mem_Rvalid = 0; Mem_Ready = 0;
      if (!p_if && $urandom_range(1, 0) == 1) begin
        p_if = 1; i_ad = $urandom & 32'hFFFF_FFFC;
      end
      if (!p_ls && $urandom_range(1, 0) == 1) begin
        p_ls = 1; l_ad = $urandom;
        l_we = 1'($urandom); l_be = 4'($urandom); l_wd = $urandom;
      end
      If_Req = p_if; If_Addr = i_ad;
      Ls_Req = p_ls; Ls_Addr = l_ad; Ls_We = l_we;
      Ls_Be = l_be; Ls_Wdata = l_wd;
      #1;
      n_cmp++;
      if (fl() !== 6'b0) begin
        n_bad++;
        $display("FAIL rnd%0d_idle: got %b want 000000", it, fl());
      end
      if (!p_if && !p_ls) continue;
      w_ls = p_ls && (!p_if || !(RR && last_ls));
      e_ad = w_ls ? l_ad : i_ad;
      stall = $urandom_range(3, 0);
      cyc();
      Mem_Ready = (stall == 0);
      #1;
      n_cmp++;
      if (fl() !== (w_ls ? 6'b010010 : 6'b100010)
          || {Mem_We, Mem_Be, Mem_Addr, Mem_Wdata}
             !== {w_ls & l_we, w_ls ? l_be : 4'hF, e_ad,
                  w_ls ? l_wd : 32'h0}) begin
        n_bad++;
        $display("FAIL rnd%0d_gnt: got %b %b %h %h %h want ls=%0d addr %h",
                 it, fl(), Mem_We, Mem_Be, Mem_Addr, Mem_Wdata, w_ls, e_ad);
      end
      if (w_ls) begin p_ls = 0; Ls_Req = 0; end
      else begin p_if = 0; If_Req = 0; end
      for (int s = 1; s <= stall; s++) begin
        cyc();
        Mem_Ready = (s == stall);
        #1;
        n_cmp++;
        if (fl() !== 6'b000010 || Mem_Addr !== e_ad) begin
          n_bad++;
          $display("FAIL rnd%0d_stall: got %b/%h want 000010/%h",
                   it, fl(), Mem_Addr, e_ad);
        end
      end
      dly = $urandom_range(2, 0);
      for (int j = 0; j < dly; j++) begin
        cyc();
        Mem_Ready = 0;
        #1;
        n_cmp++;
        if (fl() !== 6'b0) begin
          n_bad++;
          $display("FAIL rnd%0d_wait: got %b want 000000", it, fl());
        end
      end
      cyc();
      rd = $urandom;
      Mem_Ready = 0; Mem_Rvalid = 1; Mem_Rdata = rd;
      #1;
      n_cmp++;
      if (fl() !== (w_ls ? 6'b000100 : 6'b001000)
          || (!(w_ls && l_we) && Rdata !== rd)) begin
        n_bad++;
        $display("FAIL rnd%0d_resp: got %b/%h want ls=%0d/%h",
                 it, fl(), Rdata, w_ls, rd);
      end
      last_ls = w_ls;
    end
    cyc();
    Mem_Rvalid = 0; If_Req = 0; Ls_Req = 0;
    #1;
    n_cmp++;
    if (fl() !== 6'b0) begin
      n_bad++;
      $display("FAIL rnd_end: got %b want 000000", fl());
    end
  endtask

  initial begin
    test_reset();
    test_single_fetch();
    test_stall();
    test_store();
    test_conflict();
    test_protocol();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/rv32i_mem_arb.md
RV32I_MEM_ARB -- requirements
Module: rv32i_mem_arb

Interface
REQ-001 Parameter: ADDR_W, 32, byte-address width on all address ports.
REQ-002 Clk  in  1  single clock; all state updates on rising edge.
REQ-003 Rst  in  1  reset, asynchronous assert, active-low.
REQ-004 If_Req  in  1  instruction-fetch read request; held until If_Gnt seen.
REQ-005 If_Addr  in  ADDR_W  fetch address.
REQ-006 If_Gnt  out  1  one-cycle pulse: fetch request accepted.
REQ-007 If_Rvalid  out  1  one-cycle pulse: fetch response on Rdata.
REQ-008 Ls_Req  in  1  load/store request; held until Ls_Gnt seen.
REQ-009 Ls_We  in  1  1 = store, 0 = load.
REQ-010 Ls_Be  in  4  byte enables.
REQ-011 Ls_Addr  in  ADDR_W  load/store address.
REQ-012 Ls_Wdata  in  32  store data.
REQ-013 Ls_Gnt  out  1  one-cycle pulse: load/store accepted.
REQ-014 Ls_Rvalid  out  1  one-cycle pulse: load data on Rdata, or store acknowledged.
REQ-015 Rdata  out  32  response data shared by both requesters; qualified only by the owner's Rvalid.
REQ-016 Mem_Req  out  1  memory request; held until Mem_Ready.
REQ-017 Mem_We, Mem_Be, Mem_Addr, Mem_Wdata  out  1/4/ADDR_W/32  registered copy of the granted request.
REQ-018 Mem_Ready  in  1  memory accepts the request when Mem_Req && Mem_Ready at an edge.
REQ-019 Mem_Rvalid  in  1  memory response strobe, for both reads and writes.
REQ-020 Mem_Rdata  in  32  memory read data.
REQ-021 Err  out  1  sticky flag: protocol violation seen.

Function
REQ-022 The FSM SHALL have three states: IDLE, ISSUE, WAIT; at most one transaction is outstanding.
REQ-023 IDLE: at an edge where any request is high, the winner's fields and owner SHALL be latched, the state SHALL go to ISSUE, and the winner's Gnt SHALL be high for exactly the next cycle.
REQ-024 ISSUE: Mem_Req SHALL be high; at an edge with Mem_Ready the state SHALL go to WAIT; with no Mem_Ready it SHALL stay in ISSUE with fields stable.
REQ-025 WAIT: Mem_Req SHALL be low; at an edge with Mem_Rvalid the state SHALL go to IDLE; during that cycle the owner's Rvalid = 1 (combinational) and Rdata = Mem_Rdata.
REQ-026 Minimum transaction: request sampled at edge 0, Mem_Req in cycle 1, response in cycle 2 at the earliest; one IDLE cycle between transactions.
REQ-027 Default arbitration SHALL be fixed priority, Ls over If.
REQ-028 For stores, Rdata content is don't-care; Ls_Rvalid still pulses.
REQ-029 Mem_Rvalid in IDLE or ISSUE SHALL be ignored for routing and SHALL set Err; Err clears only on reset.
REQ-030 Requests arriving while not in IDLE SHALL NOT be granted until the next IDLE sample.

Reset
REQ-031 On Rst low: state = IDLE, owner = If, all Gnt/Rvalid/Mem_Req/Err = 0, Mem_* fields = 0.
REQ-032 On reset mid-transaction, the transaction SHALL be abandoned with no Rvalid emitted; a late Mem_Rvalid after release SHALL set Err.

Configuration
REQ-033 With RV32I_ARB_RR_EN defined: round-robin arbitration; the requester granted last has the lower priority on the next conflict, and after reset If has the lower priority.
REQ-034 Without RV32I_ARB_RR_EN: fixed Ls-over-If priority, with no round-robin state flop.

Structure
REQ-035 Package rv32i_pkg SHALL hold the state enum (IDLE/ISSUE/WAIT), the owner enum (OWN_IF/OWN_LS), and the constants XLEN = 32 and BE_W = 4.
REQ-036 Sub-module rv32i_arb_pick SHALL hold the combinational winner select, including the optional round-robin pointer input.

Verification
REQ-037 Single fetch: If_Req, If_Addr = 0x100, Mem_Ready immediate, Mem_Rdata = 0x00500293 the cycle after accept -> If_Gnt in cycle 1, If_Rvalid in cycle 2, Rdata = 0x00500293.
REQ-038 Conflict: If_Req and Ls_Req (load 0x2000) together -> Ls_Gnt first, If_Gnt at the next IDLE; with RR_EN and two back-to-back conflicts -> Ls then If.
REQ-039 Stall: Mem_Ready low for 3 cycles -> Mem_Req and Mem_Addr stable for 4 cycles, no Rvalid before accept.
REQ-040 Store: Ls_We = 1, Be = 0x3, Wdata = 0xDEADBEEF at 0x40 -> Mem_We = 1, Be = 0x3, Wdata matches; Ls_Rvalid on ack, If_Rvalid stays 0.
REQ-041 Protocol and reset: Mem_Rvalid in IDLE -> Err = 1 and no Rvalid; Rst low during WAIT -> all outputs 0 and state IDLE.
